// File: rtl/noc_vc_output_scheduler.sv
// noc_vc_output_scheduler
//
// Per-port output scheduler. It drains CHANNELS per-virtual-channel input
// FIFOs onto one physical link at up to one flit per cycle. Each VC has a
// credit counter that tracks free space in the downstream buffer. Eligible
// VCs are picked round-robin. When LOCK=1, a VC keeps the grant from its
// first flit until its tail flit (wormhole lock).
//
// Ports:
//   noc_clk        clock; all state changes on the rising edge
//   noc_rst        asynchronous active-high reset
//   in_valid       per-VC FIFO has a flit at its head
//   in_ready       per-VC pop strobe (one-hot or zero, combinational)
//   in_flit        per-VC head flit, VC i at [i*FLIT_W +: FLIT_W]
//   in_tail        per-VC head flit is the last flit of its packet
//   out_valid      registered link flit valid
//   out_vc         registered VC index of the link flit
//   out_flit       registered link flit (held while out_valid is 0)
//   out_tail       registered tail marker of the link flit
//   credit_return  per-VC pulse: downstream freed one slot
//   credit_err     sticky: a credit came back to a VC that was already full

module noc_vc_output_scheduler #(
  parameter int CHANNELS = 32,
  parameter int FLIT_W   = 64,
  parameter int CREDITS  = 32,
  parameter int LOCK     = 1
) (
  input  logic                         noc_clk,
  input  logic                         noc_rst,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  input  logic [CHANNELS*FLIT_W-1:0]   in_flit,
  input  logic [CHANNELS-1:0]          in_tail,
  output logic                         out_valid,
  output logic [$clog2(CHANNELS)-1:0]  out_vc,
  output logic [FLIT_W-1:0]            out_flit,
  output logic                         out_tail,
  input  logic [CHANNELS-1:0]          credit_return,
  output logic                         credit_err
);

  localparam int VC_W  = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [VC_W-1:0]  LAST_VC     = VC_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] FULL_CREDIT = CNT_W'(CREDITS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [VC_W-1:0]        rr_ptr;
  logic [VC_W-1:0]        lock_vc;
  logic [CNT_W-1:0]       credit [CHANNELS];
  logic [CHANNELS-1:0]    eligible;
  logic                   rr_found;
  logic [VC_W-1:0]        rr_vc;
  logic                   grant_valid;
  logic [VC_W-1:0]        grant_vc;
  logic                   grant_tail;
  logic [VC_W-1:0]        next_vc;

  // A VC can be served only when its FIFO has a flit and the downstream
  // buffer has room. Credits returned this cycle are not counted yet, so a
  // returned credit first makes the VC eligible in the following cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      eligible[i] = in_valid[i] && (credit[i] != '0);
    end
  end

  // Round-robin search that starts at rr_ptr and wraps modulo CHANNELS.
  // The first eligible VC met in that order wins.
  always_comb begin
    int idx;
    rr_found = 1'b0;
    rr_vc    = '0;
    idx      = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!rr_found && eligible[idx]) begin
        rr_found = 1'b1;
        rr_vc    = VC_W'(idx);
      end
    end
  end

  // FSM state register. With LOCK=0 the next-state logic never leaves IDLE,
  // so the scheduler reduces to per-flit round-robin.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) state <= IDLE;
    else         state <= state_next;
  end

  // FSM next state. A granted non-tail flit starts a locked packet. The
  // tail flit of the locked VC releases the lock. Head flits are never
  // decoded, so only the tail marks the end of a packet.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if ((LOCK != 0) && grant_valid && !grant_tail) state_next = LOCKED;
      LOCKED:  if (grant_valid && grant_tail) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: the grant. While LOCKED only the locked VC may go, even
  // when other VCs are eligible. The pop strobe is the one-hot grant, so it
  // depends only on valids, credits, rr_ptr and the FSM state.
  always_comb begin
    if (state == LOCKED) begin
      grant_valid = eligible[lock_vc];
      grant_vc    = lock_vc;
    end else begin
      grant_valid = rr_found;
      grant_vc    = rr_vc;
    end
    grant_tail = in_tail[grant_vc];
    next_vc    = (grant_vc == LAST_VC) ? '0 : grant_vc + 1'b1;
    in_ready   = '0;
    if (grant_valid) in_ready[grant_vc] = 1'b1;
  end

  // Round-robin pointer and lock register. Without locking, every grant
  // moves priority past the winner. With locking, priority moves only when
  // a packet ends, which covers both a single-flit packet granted from IDLE
  // and the tail of a locked packet (grant_vc equals lock_vc then).
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      rr_ptr  <= '0;
      lock_vc <= '0;
    end else if (grant_valid) begin
      if ((LOCK == 0) || grant_tail) rr_ptr <= next_vc;
      if ((state == IDLE) && (state_next == LOCKED)) lock_vc <= grant_vc;
    end
  end

  // Credit counters. A grant and a return in the same cycle cancel out. A
  // return to a full counter is a downstream protocol error: the counter
  // stays saturated and the sticky error flag is raised until reset.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      for (int i = 0; i < CHANNELS; i++) credit[i] <= FULL_CREDIT;
      credit_err <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (grant_valid && (grant_vc == VC_W'(i)) && !credit_return[i]) begin
          credit[i] <= credit[i] - CNT_W'(1);
        end else if (credit_return[i] && !(grant_valid && (grant_vc == VC_W'(i)))) begin
          if (credit[i] == FULL_CREDIT) credit_err <= 1'b1;
          else                          credit[i]  <= credit[i] + CNT_W'(1);
        end
      end
    end
  end

  // Link register with one cycle of latency. When there is no grant, only
  // out_valid drops and the flit fields keep their last values.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      out_valid <= 1'b0;
      out_vc    <= '0;
      out_flit  <= '0;
      out_tail  <= 1'b0;
    end else begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_vc   <= grant_vc;
        out_flit <= in_flit[int'(grant_vc)*FLIT_W +: FLIT_W];
        out_tail <= grant_tail;
      end
    end
  end

endmodule
